// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: loads ALU operands A then B serially from one pin bus on
// synchronised load strobes, then captures the ALU result and flags.
module alu_operand_sequencer #(
   parameter int DATA_W      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [DATA_W-1:0] data_in,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [3:0]        alu_flags,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic [DATA_W-1:0] result_q,
   output logic [3:0]        flags_q,
   output logic              done,
   output logic [1:0]        state_dbg
);
   typedef enum logic [1:0] {S_A = 2'b00, S_B = 2'b01, S_EXEC = 2'b10, S_DONE = 2'b11} state_t;
   state_t state;
   logic [SYNC_STAGES-1:0] load_sr, clear_sr;
   logic load_hist, load_sync, clear_sync, ld_p;
   assign load_sync  = load_sr[SYNC_STAGES-1];
   assign clear_sync = clear_sr[SYNC_STAGES-1];
   assign ld_p       = load_sync & ~load_hist;
   assign state_dbg  = state;
   // synchronisers and edge history run regardless of ena, so pulses seen while disabled are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_sr   <= '0;
         clear_sr  <= '0;
         load_hist <= 1'b0;
      end else begin
         load_sr   <= {load_sr[SYNC_STAGES-2:0], load};
         clear_sr  <= {clear_sr[SYNC_STAGES-2:0], clear};
         load_hist <= load_sync;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_A;
         a_out    <= '0;
         b_out    <= '0;
         result_q <= '0;
         flags_q  <= '0;
         done     <= 1'b0;
      end else if (ena) begin
         if (clear_sync) begin
            state    <= S_A;
            a_out    <= '0;
            b_out    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            done     <= 1'b0;
         end else begin
            case (state)
               S_A: if (ld_p) begin
                  a_out <= data_in;
                  state <= S_B;
               end
               S_B: if (ld_p) begin
                  b_out <= data_in;
                  state <= S_EXEC;
               end
               S_EXEC: begin
                  result_q <= alu_result;
                  flags_q  <= alu_flags;
                  done     <= 1'b1;
                  state    <= S_DONE;
               end
               S_DONE: if (ld_p) begin
                  a_out <= data_in;
                  done  <= 1'b0;
                  state <= S_B;
               end
            endcase
         end
      end
   end
endmodule
